merge_sort_stream: RTL and testbench

//  Streaming frame sorter. Each input beat carries LANES samples. A lane sorter orders each beat

---
 rtl/merge_sort_pkg.sv | 29 ++
 rtl/merge_sort_stream_lane_sort_net.sv | 31 +++
 rtl/merge_sort_stream.sv | 142 ++++++++++++++
 tb/tb_merge_sort_stream.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_sort_pkg.sv
// merge_sort_pkg: bank states, pointer-width helpers and the ordering compare shared by the sorter.
package merge_sort_pkg;

   typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_DRAINING} bank_state_t;

   function automatic int head_w(input int lanes);
      return $clog2(lanes + 1);
   endfunction

   function automatic int beat_w(input int groups);
      return $clog2(groups);
   endfunction

   // True when a must leave ahead of b. Left-aligning both samples lets one
   // 32-bit compare serve any width up to 32 without sign-extension logic.
   function automatic logic precedes(input logic [31:0] a, input logic [31:0] b, input int w,
                                     input logic sgn, input logic desc);
      logic [31:0] x;
      logic [31:0] y;
      logic lt;
      logic gt;
      x = a << (32 - w);
      y = b << (32 - w);
      lt = sgn ? ($signed(x) < $signed(y)) : (x < y);
      gt = sgn ? ($signed(x) > $signed(y)) : (x > y);
      return desc ? gt : lt;
   endfunction

endpackage

// File: rtl/merge_sort_stream_lane_sort_net.sv
// lane_sort_net: combinational odd-even transposition sort of one beat's lanes.
module lane_sort_net
   import merge_sort_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int SIGNED = 1
) (
   input  logic                    desc,
   input  logic [LANES*DATA_W-1:0] in_data,
   output logic [LANES*DATA_W-1:0] out_data
);

   logic [DATA_W-1:0] v [LANES];
   logic [DATA_W-1:0] t;

   always_comb begin
      t = '0;
      out_data = '0;
      for (int i = 0; i < LANES; i++) v[i] = in_data[i*DATA_W +: DATA_W];
      for (int s = 0; s < LANES; s++)
         for (int i = s % 2; i + 1 < LANES; i += 2)
            if (precedes(32'(v[i+1]), 32'(v[i]), DATA_W, SIGNED != 0, desc)) begin
               t = v[i];
               v[i] = v[i+1];
               v[i+1] = t;
            end
      for (int i = 0; i < LANES; i++) out_data[i*DATA_W +: DATA_W] = v[i];
   end

endmodule

// File: rtl/merge_sort_stream.sv
// merge_sort_stream: ping-pong frame sorter, lane-sorts each beat then merges GROUPS runs one sample per cycle.
module merge_sort_stream
   import merge_sort_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int GROUPS = 8,
   parameter int SIGNED = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic                    in_desc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic                    out_last,
   output logic                    frame_err
);

   localparam int N  = LANES * GROUPS;
   localparam int HW = head_w(LANES);
   localparam int LW = $clog2(LANES);
   localparam int BW = beat_w(GROUPS);
   localparam int CW = $clog2(N + 1);

   bank_state_t bst [2];
   bank_state_t bst_nxt [2];
   logic fill_bank;
   logic drain_bank;
   logic [BW-1:0] beat_cnt;
   logic desc_q [2];
   logic [HW-1:0] head [GROUPS];
   logic [CW-1:0] cnt;
   logic [DATA_W-1:0] mem [2][GROUPS][LANES];
   logic [LANES*DATA_W-1:0] sorted;
   logic cur_desc;
   logic acc;
   logic start;
   logic done;
   logic issue;
   logic found;
   logic [BW-1:0] sel;
   logic [DATA_W-1:0] sel_val;
   logic [DATA_W-1:0] cand;

   // The first beat of a frame has no latched order yet, so it uses in_desc directly.
   assign cur_desc = (beat_cnt == '0) ? in_desc : desc_q[fill_bank];

   lane_sort_net #(.DATA_W(DATA_W), .LANES(LANES), .SIGNED(SIGNED)) u_sort (
      .desc    (cur_desc),
      .in_data (in_data),
      .out_data(sorted)
   );

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         bst[0] <= BANK_EMPTY;
         bst[1] <= BANK_EMPTY;
      end else begin
         bst[0] <= bst_nxt[0];
         bst[1] <= bst_nxt[1];
      end

   always_comb begin
      bst_nxt[0] = bst[0];
      bst_nxt[1] = bst[1];
      if (acc) bst_nxt[fill_bank] = (beat_cnt == BW'(GROUPS - 1)) ? BANK_FULL : BANK_FILLING;
      if (start) bst_nxt[drain_bank] = BANK_DRAINING;
      if (done) bst_nxt[drain_bank] = BANK_EMPTY;
   end

   // Drains follow fills in order, so drain_bank only toggles when a frame's last sample leaves.
   always_comb begin
      in_ready = (bst[fill_bank] == BANK_EMPTY) || (bst[fill_bank] == BANK_FILLING);
      acc = in_valid && in_ready;
      start = bst[drain_bank] == BANK_FULL;
      done = (bst[drain_bank] == BANK_DRAINING) && out_valid && out_ready && out_last;
      issue = (bst[drain_bank] == BANK_DRAINING) && (!out_valid || out_ready) && (cnt != CW'(N));
   end

   // Strict compare keeps the lowest row on ties.
   always_comb begin
      found = 1'b0;
      sel = '0;
      sel_val = '0;
      cand = '0;
      for (int r = 0; r < GROUPS; r++) begin
         cand = mem[drain_bank][r][head[r][LW-1:0]];
         if (head[r] != HW'(LANES) &&
             (!found || precedes(32'(cand), 32'(sel_val), DATA_W, SIGNED != 0, desc_q[drain_bank]))) begin
            found = 1'b1;
            sel = BW'(r);
            sel_val = cand;
         end
      end
   end

   always_ff @(posedge clk)
      if (acc)
         for (int l = 0; l < LANES; l++) mem[fill_bank][beat_cnt][l] <= sorted[l*DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         fill_bank <= 1'b0;
         drain_bank <= 1'b0;
         beat_cnt <= '0;
         desc_q[0] <= 1'b0;
         desc_q[1] <= 1'b0;
         cnt <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         out_last <= 1'b0;
         frame_err <= 1'b0;
         for (int r = 0; r < GROUPS; r++) head[r] <= '0;
      end else begin
         if (acc) begin
            beat_cnt <= beat_cnt + BW'(1);
            if (beat_cnt == '0) desc_q[fill_bank] <= in_desc;
            else if (in_desc != desc_q[fill_bank]) frame_err <= 1'b1;
            if (beat_cnt == BW'(GROUPS - 1)) fill_bank <= ~fill_bank;
         end
         if (issue) begin
            out_valid <= 1'b1;
            out_data <= sel_val;
            out_last <= cnt == CW'(N - 1);
            cnt <= cnt + CW'(1);
            head[sel] <= head[sel] + HW'(1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
         end
         if (done) begin
            drain_bank <= ~drain_bank;
            cnt <= '0;
            for (int r = 0; r < GROUPS; r++) head[r] <= '0;
         end
      end

endmodule

// File: tb/tb_merge_sort_stream.sv
// tb_merge_sort_stream: directed frames through signed and unsigned sorter instances with hand-derived expectations.
module tb_merge_sort_stream;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic in_desc = 1'b0;
   logic out_ready = 1'b1;
   logic [31:0] in_data = '0;
   logic in_ready, out_valid, out_last, frame_err;
   logic u_in_ready, u_out_valid, u_out_last, u_frame_err;
   logic [7:0] out_data, u_out_data;
   int checks = 0;
   int errors = 0;
   int stall_bad = 0;
   logic [8:0] q_s [$];
   logic [8:0] q_u [$];
   logic stalled = 1'b0;
   logic [8:0] held = '0;

   always #5 clk = ~clk;

   merge_sort_stream dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_desc(in_desc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .frame_err(frame_err)
   );

   merge_sort_stream #(.SIGNED(0)) dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
      .in_desc(in_desc), .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data),
      .out_last(u_out_last), .frame_err(u_frame_err)
   );

   always @(negedge clk)
      if (!rst) stalled <= 1'b0;
      else begin
         if (stalled && (!out_valid || {out_last, out_data} != held)) stall_bad <= stall_bad + 1;
         if (out_valid && out_ready) q_s.push_back({out_last, out_data});
         if (u_out_valid && out_ready) q_u.push_back({u_out_last, u_out_data});
         stalled <= out_valid && !out_ready;
         held <= {out_last, out_data};
      end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input logic desc);
      int t = 0;
      in_valid = 1'b1;
      in_data = d;
      in_desc = desc;
      @(negedge clk);
      while (!in_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) begin
         checks++;
         errors++;
         $error("FAIL beat accept timeout: observed in_ready=0 expected 1 within 2000 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [255:0] f, input logic desc, input int flip_beat);
      for (int j = 0; j < 8; j++) send_beat(f[j*32 +: 32], (j == flip_beat) ? ~desc : desc);
      in_valid = 1'b0;
   endtask

   task automatic check_frame(input string tag, input logic [255:0] exp, input bit use_u, input int base);
      int t = 0;
      while ((use_u ? q_u.size() : q_s.size()) < base + 32 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) begin
         checks++;
         errors++;
         $error("FAIL %s timeout: observed %0d outputs expected %0d", tag,
                use_u ? q_u.size() : q_s.size(), base + 32);
      end else
         for (int k = 0; k < 32; k++) begin
            logic [8:0] g;
            g = use_u ? q_u[base+k] : q_s[base+k];
            chk($sformatf("%s data[%0d]", tag, k), 32'(g[7:0]), 32'(exp[k*8 +: 8]));
            chk($sformatf("%s last[%0d]", tag, k), 32'(g[8]), 32'(k == 31));
         end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [255:0] f, e, g, fa, fb, fc, ea, eb, ec;
      logic [7:0] vs [4];
      logic [7:0] es [4];
      logic [7:0] eu [4];
      int n0;
      int t;
      vs[0] = 8'h80; vs[1] = 8'hFF; vs[2] = 8'h00; vs[3] = 8'h7F;
      es[0] = 8'h80; es[1] = 8'hFF; es[2] = 8'h00; es[3] = 8'h7F;
      eu[0] = 8'h00; eu[1] = 8'h7F; eu[2] = 8'h80; eu[3] = 8'hFF;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_data", out_data, 0);
      chk("reset out_last", out_last, 0);
      chk("reset frame_err", frame_err, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("release in_ready", in_ready, 1);
      chk("release out_valid", out_valid, 0);
      @(posedge clk);
      #1;

      // 1: ascending beats, descending frame, latency of two cycles
      for (int k = 0; k < 32; k++) begin
         f[k*8 +: 8] = 8'(k);
         e[k*8 +: 8] = 8'(31 - k);
      end
      send_frame(f, 1'b1, 8);
      @(negedge clk);
      chk("t1 latency c1", out_valid, 0);
      @(negedge clk);
      chk("t1 latency c2", out_valid, 0);
      @(negedge clk);
      chk("t1 latency c3", out_valid, 1);
      check_frame("t1", e, 0, 0);
      q_s.delete(); q_u.delete();

      // 2: extremes, signed and unsigned compare
      for (int k = 0; k < 32; k++) begin
         f[k*8 +: 8] = vs[(k + k / 4) % 4];
         e[k*8 +: 8] = es[k / 8];
         g[k*8 +: 8] = eu[k / 8];
      end
      send_frame(f, 1'b0, 8);
      check_frame("t2 signed", e, 0, 0);
      check_frame("t2 unsigned", g, 1, 0);
      q_s.delete(); q_u.delete();

      // 3: all ties
      for (int k = 0; k < 32; k++) begin
         f[k*8 +: 8] = 8'd5;
         e[k*8 +: 8] = 8'd5;
      end
      send_frame(f, 1'b0, 8);
      check_frame("t3", e, 0, 0);
      q_s.delete(); q_u.delete();

      // 4: random backpressure during drain
      for (int k = 0; k < 32; k++) begin
         f[k*8 +: 8] = 8'(k);
         e[k*8 +: 8] = 8'(k);
      end
      send_frame(f, 1'b0, 8);
      t = 0;
      while (q_s.size() < 32 && t < 3000) begin
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         t++;
      end
      out_ready = 1'b1;
      check_frame("t4", e, 0, 0);
      chk("t4 stall hold", stall_bad, 0);
      chk("t4 frame_err clear", frame_err, 0);
      q_s.delete(); q_u.delete();

      // in_desc toggled on beat 3: latched ascending order kept, error flagged
      for (int k = 0; k < 32; k++) begin
         f[k*8 +: 8] = 8'(31 - k);
         e[k*8 +: 8] = 8'(k);
      end
      send_frame(f, 1'b0, 3);
      check_frame("terr", e, 0, 0);
      chk("terr frame_err", frame_err, 1);
      q_s.delete(); q_u.delete();

      // 5: three frames against a stalled sink
      for (int k = 0; k < 32; k++) begin
         fa[k*8 +: 8] = 8'(k);
         ea[k*8 +: 8] = 8'(31 - k);
         fb[k*8 +: 8] = 8'(71 - k);
         eb[k*8 +: 8] = 8'(40 + k);
         fc[k*8 +: 8] = 8'(64 + (5 * k) % 32);
         ec[k*8 +: 8] = 8'(95 - k);
      end
      out_ready = 1'b0;
      send_frame(fa, 1'b1, 8);
      send_frame(fb, 1'b0, 8);
      in_valid = 1'b1;
      in_data = fc[31:0];
      in_desc = 1'b1;
      @(negedge clk);
      chk("t5 in_ready after 16", in_ready, 0);
      repeat (3) @(negedge clk);
      chk("t5 in_ready held", in_ready, 0);
      chk("t5 stall valid", out_valid, 1);
      chk("t5 stall data", out_data, 31);
      chk("t5 stall last", out_last, 0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      send_frame(fc, 1'b1, 8);
      check_frame("t5 frame1", ea, 0, 0);
      check_frame("t5 frame2", eb, 0, 32);
      check_frame("t5 frame3", ec, 0, 64);
      chk("t5 stall hold", stall_bad, 0);
      q_s.delete(); q_u.delete();

      // 6: reset after ten outputs, then a clean frame
      for (int k = 0; k < 32; k++) f[k*8 +: 8] = 8'(k);
      send_frame(f, 1'b0, 8);
      t = 0;
      while (q_s.size() < 10 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("t6 reached ten outputs", 32'(q_s.size() >= 10), 1);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6 in reset out_valid", out_valid, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("t6 out_valid", out_valid, 0);
      chk("t6 in_ready", in_ready, 1);
      chk("t6 frame_err cleared", frame_err, 0);
      n0 = q_s.size();
      repeat (40) @(negedge clk);
      chk("t6 no stale output", q_s.size(), n0);
      @(posedge clk);
      #1;
      q_s.delete(); q_u.delete();
      for (int k = 0; k < 32; k++) e[k*8 +: 8] = 8'(64 + k);
      send_frame(fc, 1'b0, 8);
      check_frame("t6 new frame", e, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
